// File: rtl/instr_dispatch_queue_pkg.sv
// instr_dispatch_queue_pkg: instruction type codes, field widths and queue entry sizing
package instr_dispatch_queue_pkg;
  typedef enum logic [1:0] {
    INSTR_TYPE_RAM        = 2'd0,
    INSTR_TYPE_LOAD_STORE = 2'd1,
    INSTR_TYPE_ARITHMETIC = 2'd2,
    INSTR_TYPE_LOOP       = 2'd3
  } instr_type_e;
  localparam int INSTR_W        = 14;
  localparam int RAM_INSTR_W    = 9;
  localparam int LDST_INSTR_W   = 10;
  localparam int ARITH_INSTR_W  = 14;
  localparam int ADDR_W_DEFAULT = 18;
  function automatic int entry_w(input int addr_w);
    return 2 + INSTR_W + 2 * addr_w;
  endfunction
endpackage

// File: rtl/instr_dispatch_queue_if.sv
// instr_dispatch_queue_if: push port from control_unit plus the three execution-unit handshakes
interface instr_dispatch_queue_if import instr_dispatch_queue_pkg::*; #(parameter int ADDR_W = ADDR_W_DEFAULT);
  logic                     queue_we;
  instr_type_e              queue_instr_type;
  logic [INSTR_W-1:0]       queue_instr;
  logic [ADDR_W-1:0]        cache_addr;
  logic [ADDR_W-1:0]        main_mem_addr;
  logic                     queue_full;
  logic                     ram_valid;
  logic                     ram_ready;
  logic [RAM_INSTR_W-1:0]   ram_instr;
  logic                     ldst_valid;
  logic                     ldst_ready;
  logic [LDST_INSTR_W-1:0]  ldst_instr;
  logic                     arith_valid;
  logic                     arith_ready;
  logic [ARITH_INSTR_W-1:0] arith_instr;
  logic [ADDR_W-1:0]        disp_cache_addr;
  logic [ADDR_W-1:0]        disp_main_mem_addr;
  logic                     ram_done;
  logic                     idle;
  logic                     dispatch_error;
  modport master (
    output queue_we, queue_instr_type, queue_instr, cache_addr, main_mem_addr,
    output ram_ready, ldst_ready, arith_ready, ram_done,
    input  queue_full, ram_valid, ram_instr, ldst_valid, ldst_instr, arith_valid, arith_instr,
    input  disp_cache_addr, disp_main_mem_addr, idle, dispatch_error
  );
  modport slave (
    input  queue_we, queue_instr_type, queue_instr, cache_addr, main_mem_addr,
    input  ram_ready, ldst_ready, arith_ready, ram_done,
    output queue_full, ram_valid, ram_instr, ldst_valid, ldst_instr, arith_valid, arith_instr,
    output disp_cache_addr, disp_main_mem_addr, idle, dispatch_error
  );
endinterface

// File: rtl/instr_dispatch_queue_sync_fifo.sv
// instr_dispatch_queue_sync_fifo: power-of-2 FIFO; a push while full is refused even if a pop happens
module instr_dispatch_queue_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/instr_dispatch_queue.sv
// instr_dispatch_queue: in-order issue queue steering head instructions to RAM, load/store and arithmetic units
module instr_dispatch_queue import instr_dispatch_queue_pkg::*; #(
  parameter int DEPTH       = 8,
  parameter int MAX_RAM_OUT = 4,
  parameter int ADDR_W      = ADDR_W_DEFAULT
) (
  input logic                    clk,
  input logic                    reset,
  instr_dispatch_queue_if.slave  q
);
  localparam int EW = entry_w(ADDR_W);
  localparam int OW = $clog2(MAX_RAM_OUT+1);
  localparam int CW = $clog2(DEPTH+1);
  logic [EW-1:0]      head;
  logic [1:0]         head_type;
  logic [INSTR_W-1:0] head_instr;
  logic               full, empty, is_loop, drop, pop;
  logic               ram_fire, ldst_fire, arith_fire, done_ok, bad_done;
  logic [CW-1:0]      count;
  logic [OW-1:0]      ram_out;
  logic               err;
  assign is_loop = q.queue_instr_type == INSTR_TYPE_LOOP;
  assign drop    = q.queue_we & (full | is_loop);
  instr_dispatch_queue_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (q.queue_we & ~is_loop),
    .pop   (pop),
    .din   ({q.queue_instr_type, q.queue_instr, q.cache_addr, q.main_mem_addr}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign {head_type, head_instr, q.disp_cache_addr, q.disp_main_mem_addr} = head;
  assign q.ram_instr   = head_instr[INSTR_W-1 -: RAM_INSTR_W];
  assign q.ldst_instr  = head_instr[INSTR_W-1 -: LDST_INSTR_W];
  assign q.arith_instr = head_instr[INSTR_W-1 -: ARITH_INSTR_W];
  // Load/store must not overtake any RAM transfer still in flight
  assign q.ram_valid   = ~empty & (head_type == INSTR_TYPE_RAM) & (ram_out < OW'(MAX_RAM_OUT));
  assign q.ldst_valid  = ~empty & (head_type == INSTR_TYPE_LOAD_STORE) & (ram_out == '0);
  assign q.arith_valid = ~empty & (head_type == INSTR_TYPE_ARITHMETIC);
  assign ram_fire   = q.ram_valid & q.ram_ready;
  assign ldst_fire  = q.ldst_valid & q.ldst_ready;
  assign arith_fire = q.arith_valid & q.arith_ready;
  assign pop        = ram_fire | ldst_fire | arith_fire;
  assign done_ok    = q.ram_done & (ram_out != '0);
  assign bad_done   = q.ram_done & (ram_out == '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ram_out <= '0;
      err     <= 1'b0;
    end else begin
      ram_out <= ram_out + OW'(ram_fire) - OW'(done_ok);
      if (drop | bad_done) err <= 1'b1;
    end
  assign q.queue_full     = full;
  assign q.idle           = (count == '0) & (ram_out == '0);
  assign q.dispatch_error = err;
endmodule
